servo_move_seq: RTL
===================

Name: servo_move_seq

Overview:
- Upstream command stage for the servo PWM generator. Accepts angle commands over a valid/ready handshake and converts each angle to a pulse-width count.
- Slews the duty count toward the new target by a bounded step once per PWM frame, then holds it for a settle interval before reporting done.
- Drives the generator's duty (d) and period (t) count inputs directly. Limits servo slew current so cube-face turns do not jerk.

Parameters:
PERIOD_CNT, 1000000, clk cycles per PWM frame (20 ms at 50 MHz); driven on t
MIN_CNT, 25000, duty count for 0 degrees
STEP_CNT, 555, duty counts per degree
MAX_POS, 180, highest legal angle; larger commands are clamped
RAMP_CNT, 2775, maximum change of d per frame
SETTLE_FRAMES, 5, frames held at target before done
POS_W, 8, command angle width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_pos  in  POS_W  target angle in degrees
cmd_ready  out  1  block can accept a command (high only in IDLE)
stop  in  1  abort the current move, hold the present duty
d  out  32  duty count to the PWM generator
t  out  32  period count to the PWM generator; constant PERIOD_CNT
busy  out  1  high in RAMP or SETTLE
done  out  1  one-cycle pulse when a move completes
cmd_clamped  out  1  one-cycle pulse when an accepted cmd_pos exceeded MAX_POS
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
Reset values:
- d = HOME = MIN_CNT + (MAX_POS/2)*STEP_CNT. With default parameters this is 74950.
- t = PERIOD_CNT; frame counter = 0; state = IDLE.
- cmd_ready = 1; busy, done, cmd_clamped, frame_tick = 0.
- Reset asserted mid-move forces all of the above on the next edge.

Frame counter:
- Free-running 0..PERIOD_CNT-1, wrapping to 0.
- frame_tick (registered) is high while counter == PERIOD_CNT-1.
- All d updates happen on the edge that ends a frame_tick cycle. New d is therefore visible from counter = 0 and constant for the whole frame.

State machine:
- IDLE: cmd_ready = 1.
  - On cmd_valid & cmd_ready: pos_eff = min(cmd_pos, MAX_POS).
  - target = MIN_CNT + pos_eff*STEP_CNT, 32-bit unsigned, computed and registered on the accept edge.
  - cmd_clamped pulses on the cycle after accept if cmd_pos > MAX_POS.
  - Go to RAMP; cmd_ready falls on the cycle after accept.
- RAMP: on each frame_tick, with diff = |target - d|:
  - If diff <= RAMP_CNT: d <= target, settle_cnt <= 0, go to SETTLE.
  - Otherwise d <= d + RAMP_CNT (target > d) or d - RAMP_CNT (target < d).
  - A command equal to the current d therefore reaches SETTLE at the first frame_tick.
- SETTLE: on each frame_tick, settle_cnt increments.
  - When settle_cnt reaches SETTLE_FRAMES-1 on a tick: done = 1 for the cycle after that edge, state goes to IDLE.
  - With SETTLE_FRAMES = 0: done is issued on the cycle after entering SETTLE.

Stop and boundary rules:
- stop, sampled every cycle in RAMP or SETTLE: go to IDLE on the next edge, d frozen at its current value, no done.
- stop in IDLE has no effect.
- stop and frame_tick in the same cycle: stop wins, d is not updated.
- cmd_valid is ignored while cmd_ready = 0. The master must hold cmd_valid and cmd_pos until accepted.
- A new command is accepted no earlier than the cycle after done.
- d never leaves [MIN_CNT, MIN_CNT + MAX_POS*STEP_CNT]. No subtraction may underflow.
- t never changes after reset.

Test Plan:
Sim parameters for all scenarios: PERIOD_CNT=1000, MIN_CNT=100, STEP_CNT=4, MAX_POS=180, RAMP_CNT=50, SETTLE_FRAMES=2; HOME=460.
1. Reset release -> d=460, t=1000, cmd_ready=1, busy=0; frame_tick first pulses at cycle 999, then every 1000 cycles.
2. cmd_pos=0 accepted -> at successive ticks d = 410, 360, 310, 260, 210, 160, 110, 100 (8 frames), each change appearing at counter 0. Then 2 settle frames, done pulses once, cmd_ready returns to 1.
3. cmd_pos=200 from HOME -> cmd_clamped pulses once, target=820, d rises in steps of 50 and ends at exactly 820; d never exceeds 820.
4. cmd_pos=90 from HOME (target = d) -> first tick enters SETTLE, done after 2 frames, d stays 460 throughout.
5. Move to 0, stop asserted when d=260, coincident with a frame_tick -> d stays 260, state IDLE, no done, next command accepted normally.
6. Reset asserted mid-RAMP at d=310 -> next edge d=460, busy=0, cmd_ready=1; cmd_valid held high through reset is not accepted until reset deasserts.

Source files
------------

// File: rtl/servo_move_seq.sv
// ============================================================================
// Module   : servo_move_seq
// Purpose  : Angle-command front end for the servo PWM generator; slews duty
//            toward each target by a bounded step per frame, then settles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module servo_move_seq #(
  parameter int unsigned PERIOD_CNT    = 1000000,
  parameter int unsigned MIN_CNT       = 25000,
  parameter int unsigned STEP_CNT      = 555,
  parameter int unsigned MAX_POS       = 180,
  parameter int unsigned RAMP_CNT      = 2775,
  parameter int unsigned SETTLE_FRAMES = 5,
  parameter int unsigned POS_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [POS_W-1:0] cmd_pos,
  output logic             cmd_ready,
  input  logic             stop,
  output logic [31:0]      d,
  output logic [31:0]      t,
  output logic             busy,
  output logic             done,
  output logic             cmd_clamped,
  output logic             frame_tick
);

  localparam logic [31:0] c_period      = 32'(PERIOD_CNT);
  localparam logic [31:0] c_period_last = 32'(PERIOD_CNT - 1);
  localparam logic [31:0] c_min         = 32'(MIN_CNT);
  localparam logic [31:0] c_step        = 32'(STEP_CNT);
  localparam logic [31:0] c_max_pos     = 32'(MAX_POS);
  localparam logic [31:0] c_ramp        = 32'(RAMP_CNT);
  localparam logic [31:0] c_home        = 32'(MIN_CNT + (MAX_POS / 2) * STEP_CNT);
  localparam logic [31:0] c_settle_last =
    (SETTLE_FRAMES == 0) ? 32'd0 : 32'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_frame_cnt;
  logic [31:0] w_frame_cnt_next;
  logic        r_tick;
  logic [31:0] r_d;
  logic [31:0] w_d_next;
  logic [31:0] r_target;
  logic [31:0] w_target_next;
  logic [31:0] r_settle_cnt;
  logic [31:0] w_settle_next;
  logic        r_done;
  logic        w_done_next;
  logic        r_clamped;
  logic        w_clamped_next;

  logic [31:0] w_pos_ext;
  logic        w_over;
  logic [31:0] w_pos_eff;
  logic [31:0] w_target_cmd;
  logic        w_up;
  logic [31:0] w_diff;

  // Frame timebase; tick is registered so it lines up with the last count.
  assign w_frame_cnt_next = (r_frame_cnt == c_period_last) ? 32'd0 : r_frame_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= 32'd0;
      r_tick      <= 1'b0;
    end else begin
      r_frame_cnt <= w_frame_cnt_next;
      r_tick      <= (w_frame_cnt_next == c_period_last);
    end
  end

  assign w_pos_ext    = 32'(cmd_pos);
  assign w_over       = (w_pos_ext > c_max_pos);
  assign w_pos_eff    = w_over ? c_max_pos : w_pos_ext;
  assign w_target_cmd = c_min + w_pos_eff * c_step;

  // Magnitude is taken by ordered subtraction so neither branch can wrap.
  assign w_up   = (r_target > r_d);
  assign w_diff = w_up ? (r_target - r_d) : (r_d - r_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_d          <= c_home;
      r_target     <= c_home;
      r_settle_cnt <= 32'd0;
      r_done       <= 1'b0;
      r_clamped    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_d          <= w_d_next;
      r_target     <= w_target_next;
      r_settle_cnt <= w_settle_next;
      r_done       <= w_done_next;
      r_clamped    <= w_clamped_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_d_next       = r_d;
    w_target_next  = r_target;
    w_settle_next  = r_settle_cnt;
    w_done_next    = 1'b0;
    w_clamped_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_target_next  = w_target_cmd;
          w_clamped_next = w_over;
          w_state_next   = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // stop outranks a coincident tick: the duty freezes where it is.
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (r_tick) begin
          if (w_diff <= c_ramp) begin
            w_d_next      = r_target;
            w_settle_next = 32'd0;
            w_state_next  = ST_SETTLE;
          end else if (w_up) begin
            w_d_next = r_d + c_ramp;
          end else begin
            w_d_next = r_d - c_ramp;
          end
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (SETTLE_FRAMES == 0) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_tick) begin
          if (r_settle_cnt == c_settle_last) begin
            w_done_next  = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_settle_next = r_settle_cnt + 32'd1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_RAMP) || (r_state == ST_SETTLE);
  assign d           = r_d;
  assign t           = c_period;
  assign done        = r_done;
  assign cmd_clamped = r_clamped;
  assign frame_tick  = r_tick;

endmodule

`default_nettype wire
